pipe_stage_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core: the consumer of the hazard unit's stall and flush requests. It owns the PC register, per-stage valid bits, and the write enables for IF/ID, ID/EX, EX/MEM and MEM/WB. It turns stall and flush requests into register holds and bubble insertion, freezes the whole pipe while data memory is busy, and keeps cycle, retire, stall and flush counters.

---
 rtl/pipe_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - 5-stage pipeline sequencing: PC, stage valids, register enables, perf counters
module pipe_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_IF,
  input  logic             stall_ID,
  input  logic             flush_ID,
  input  logic             flush_EX,
  input  logic             EX_br_sel,
  input  logic [31:0]      br_target,
  input  logic             mem_busy,
  output logic [31:0]      pc_IF,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             valid_ID,
  output logic             valid_EX,
  output logic             valid_MEM,
  output logic             valid_WB,
  output logic             retire,
  output logic             misalign,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_retire,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  logic [31:0]      pc_q, pc_d;
  logic             valid_id_q, valid_id_d;
  logic             valid_ex_q, valid_ex_d;
  logic             valid_mem_q, valid_mem_d;
  logic             valid_wb_q, valid_wb_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_cycle_q, cnt_cycle_d;
  logic [CNT_W-1:0] cnt_retire_q, cnt_retire_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  logic advance;

  // A cycle advances the pipe only outside reset and while data memory is ready
  always_comb begin
    advance  = !rst && !mem_busy;
    en_IFID  = advance && (!stall_ID || flush_ID);
    en_IDEX  = advance;
    en_EXMEM = advance;
    en_MEMWB = advance;
    retire   = valid_wb_q && !mem_busy && !rst;
  end

  // Next-state for PC, valids, sticky misalign and counters; a branch overrides any stall
  always_comb begin
    pc_d        = pc_q;
    valid_id_d  = valid_id_q;
    valid_ex_d  = valid_ex_q;
    valid_mem_d = valid_mem_q;
    valid_wb_d  = valid_wb_q;
    misalign_d  = misalign_q;
    if (!mem_busy) begin
      if (EX_br_sel) begin
        pc_d = {br_target[31:2], 2'b00};
      end else if (!stall_IF) begin
        pc_d = pc_q + 32'd4;
      end
      if (EX_br_sel && (br_target[1:0] != 2'b00)) begin
        misalign_d = 1'b1;
      end
      if (flush_ID || EX_br_sel) begin
        valid_id_d = 1'b0;
      end else if (!stall_ID) begin
        valid_id_d = 1'b1;
      end
      valid_ex_d  = valid_id_q && !(flush_EX || EX_br_sel);
      valid_mem_d = valid_ex_q;
      valid_wb_d  = valid_mem_q;
    end

    cnt_cycle_d  = cnt_cycle_q + CNT_W'(1);
    cnt_retire_d = retire ? cnt_retire_q + CNT_W'(1) : cnt_retire_q;
    cnt_stall_d  = (mem_busy || (stall_IF && !EX_br_sel)) ? cnt_stall_q + CNT_W'(1) : cnt_stall_q;
    cnt_flush_d  = (EX_br_sel && !mem_busy) ? cnt_flush_q + CNT_W'(1) : cnt_flush_q;
  end

  // State registers; reset drops every in-flight instruction and clears counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      valid_id_q   <= 1'b0;
      valid_ex_q   <= 1'b0;
      valid_mem_q  <= 1'b0;
      valid_wb_q   <= 1'b0;
      misalign_q   <= 1'b0;
      cnt_cycle_q  <= '0;
      cnt_retire_q <= '0;
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      valid_id_q   <= valid_id_d;
      valid_ex_q   <= valid_ex_d;
      valid_mem_q  <= valid_mem_d;
      valid_wb_q   <= valid_wb_d;
      misalign_q   <= misalign_d;
      cnt_cycle_q  <= cnt_cycle_d;
      cnt_retire_q <= cnt_retire_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign pc_IF      = pc_q;
  assign valid_ID   = valid_id_q;
  assign valid_EX   = valid_ex_q;
  assign valid_MEM  = valid_mem_q;
  assign valid_WB   = valid_wb_q;
  assign misalign   = misalign_q;
  assign cnt_cycle  = cnt_cycle_q;
  assign cnt_retire = cnt_retire_q;
  assign cnt_stall  = cnt_stall_q;
  assign cnt_flush  = cnt_flush_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - directed self-checking bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_IF = 1'b0, stall_ID = 1'b0, flush_ID = 1'b0, flush_EX = 1'b0;
  logic        EX_br_sel = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        mem_busy = 1'b0;

  logic [31:0] pc_IF;
  logic        en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic        valid_ID, valid_EX, valid_MEM, valid_WB, retire, misalign;
  logic [31:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;

  logic [31:0] pc2;
  logic        en2_ifid, en2_idex, en2_exmem, en2_memwb;
  logic        v2_id, v2_ex, v2_mem, v2_wb, retire2, misalign2;
  logic [3:0]  c2_cycle, c2_retire, c2_stall, c2_flush;

  int errors = 0;
  int checks = 0;

  pipe_stage_ctrl dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .flush_EX(flush_EX), .EX_br_sel(EX_br_sel), .br_target(br_target), .mem_busy(mem_busy),
    .pc_IF(pc_IF), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
    .valid_ID(valid_ID), .valid_EX(valid_EX), .valid_MEM(valid_MEM), .valid_WB(valid_WB),
    .retire(retire), .misalign(misalign), .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  pipe_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .flush_EX(flush_EX), .EX_br_sel(EX_br_sel), .br_target(br_target), .mem_busy(mem_busy),
    .pc_IF(pc2), .en_IFID(en2_ifid), .en_IDEX(en2_idex), .en_EXMEM(en2_exmem), .en_MEMWB(en2_memwb),
    .valid_ID(v2_id), .valid_EX(v2_ex), .valid_MEM(v2_mem), .valid_WB(v2_wb),
    .retire(retire2), .misalign(misalign2), .cnt_cycle(c2_cycle), .cnt_retire(c2_retire),
    .cnt_stall(c2_stall), .cnt_flush(c2_flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_IF = 1'b0; stall_ID = 1'b0; flush_ID = 1'b0; flush_EX = 1'b0;
    EX_br_sel = 1'b0; br_target = 32'h0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] ens;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    #1;
    ens = {en_IFID, en_IDEX, en_EXMEM, en_MEMWB};
    checks++; if (ens !== 4'b0) begin errors++; $display("FAIL rst_en got=%b exp=0000", ens); end
    checks++; if (pc_IF !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=00000000", pc_IF); end
    checks++; if ({valid_ID, valid_EX, valid_MEM, valid_WB, misalign, retire} !== 6'b0) begin
      errors++; $display("FAIL rst_valid got=%b exp=000000", {valid_ID, valid_EX, valid_MEM, valid_WB, misalign, retire}); end
    checks++; if ({cnt_cycle, cnt_retire, cnt_stall, cnt_flush} !== 128'h0) begin
      errors++; $display("FAIL rst_cnt got=%0d/%0d/%0d/%0d exp=0", cnt_cycle, cnt_retire, cnt_stall, cnt_flush); end
    rst = 1'b0;
    #1;
    checks++; if (en_IFID !== 1'b1) begin errors++; $display("FAIL run_en_ifid got=%b exp=1", en_IFID); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (pc_IF !== 32'(4 * i)) begin errors++; $display("FAIL fill_pc[%0d] got=%h exp=%h", i, pc_IF, 32'(4 * i)); end
      checks++; if (valid_WB !== (i >= 4)) begin errors++; $display("FAIL fill_vwb[%0d] got=%b exp=%b", i, valid_WB, (i >= 4)); end
    end
    checks++; if (cnt_retire !== 32'd6) begin errors++; $display("FAIL fill_retire got=%0d exp=6", cnt_retire); end
    checks++; if (cnt_cycle !== 32'd10) begin errors++; $display("FAIL fill_cycle got=%0d exp=10", cnt_cycle); end
  endtask

  task automatic test_branch();
    logic [4:0] exp_ret;
    do_reset();
    repeat (8) step();
    checks++; if (pc_IF !== 32'h20) begin errors++; $display("FAIL br_pre_pc got=%h exp=00000020", pc_IF); end
    EX_br_sel = 1'b1; br_target = 32'h100;
    step();
    idle_inputs();
    checks++; if (pc_IF !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=00000100", pc_IF); end
    checks++; if ({valid_ID, valid_EX, valid_MEM} !== 3'b001) begin errors++; $display("FAIL br_valid got=%b exp=001", {valid_ID, valid_EX, valid_MEM}); end
    checks++; if (cnt_flush !== 32'd1) begin errors++; $display("FAIL br_cnt_flush got=%0d exp=1", cnt_flush); end
    exp_ret = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (retire !== exp_ret[i]) begin errors++; $display("FAIL br_retire[N+%0d] got=%b exp=%b", i + 1, retire, exp_ret[i]); end
      step();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    repeat (16) step();
    stall_IF = 1'b1; stall_ID = 1'b1; flush_EX = 1'b1;
    #1;
    checks++; if ({en_IFID, en_IDEX} !== 2'b01) begin errors++; $display("FAIL lu_en got=%b exp=01", {en_IFID, en_IDEX}); end
    step();
    idle_inputs();
    checks++; if (pc_IF !== 32'h40) begin errors++; $display("FAIL lu_pc_hold got=%h exp=00000040", pc_IF); end
    checks++; if ({valid_ID, valid_EX} !== 2'b10) begin errors++; $display("FAIL lu_valid got=%b exp=10", {valid_ID, valid_EX}); end
    checks++; if (cnt_stall !== 32'd1) begin errors++; $display("FAIL lu_cnt_stall got=%0d exp=1", cnt_stall); end
    step();
    checks++; if (pc_IF !== 32'h44) begin errors++; $display("FAIL lu_pc_next got=%h exp=00000044", pc_IF); end
    checks++; if (valid_MEM !== 1'b0) begin errors++; $display("FAIL lu_vmem got=%b exp=0", valid_MEM); end
  endtask

  task automatic test_freeze();
    do_reset();
    repeat (6) step();
    mem_busy = 1'b1; EX_br_sel = 1'b1; br_target = 32'h200; stall_IF = 1'b1; flush_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({en_IFID, en_IDEX, en_EXMEM, en_MEMWB, retire} !== 5'b0) begin
        errors++; $display("FAIL frz_en[%0d] got=%b exp=00000", i, {en_IFID, en_IDEX, en_EXMEM, en_MEMWB, retire}); end
      step();
      checks++; if (pc_IF !== 32'h18) begin errors++; $display("FAIL frz_pc[%0d] got=%h exp=00000018", i, pc_IF); end
      checks++; if ({valid_ID, valid_EX, valid_MEM, valid_WB} !== 4'hF) begin
        errors++; $display("FAIL frz_valid[%0d] got=%b exp=1111", i, {valid_ID, valid_EX, valid_MEM, valid_WB}); end
    end
    idle_inputs();
    checks++; if (cnt_cycle !== 32'd9) begin errors++; $display("FAIL frz_cycle got=%0d exp=9", cnt_cycle); end
    checks++; if (cnt_stall !== 32'd3) begin errors++; $display("FAIL frz_stall got=%0d exp=3", cnt_stall); end
    checks++; if (cnt_flush !== 32'd0) begin errors++; $display("FAIL frz_flush got=%0d exp=0", cnt_flush); end
    checks++; if (cnt_retire !== 32'd2) begin errors++; $display("FAIL frz_retire_cnt got=%0d exp=2", cnt_retire); end
    #1;
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL frz_resume_retire got=%b exp=1", retire); end
    step();
    checks++; if (pc_IF !== 32'h1c) begin errors++; $display("FAIL frz_resume_pc got=%h exp=0000001c", pc_IF); end
    checks++; if (cnt_retire !== 32'd3) begin errors++; $display("FAIL frz_resume_cnt got=%0d exp=3", cnt_retire); end
    rst = 1'b1;
    #1;
    checks++; if ({retire, en_IFID, en_MEMWB} !== 3'b0) begin errors++; $display("FAIL midrst_comb got=%b exp=000", {retire, en_IFID, en_MEMWB}); end
    step();
    rst = 1'b0;
    checks++; if ({valid_ID, valid_WB, cnt_retire} !== 34'h0) begin
      errors++; $display("FAIL midrst_state got=%b%b/%0d exp=00/0", valid_ID, valid_WB, cnt_retire); end
  endtask

  task automatic test_branch_stall_misalign();
    do_reset();
    repeat (5) step();
    EX_br_sel = 1'b1; stall_IF = 1'b1; stall_ID = 1'b1; br_target = 32'h102;
    step();
    idle_inputs();
    checks++; if (pc_IF !== 32'h100) begin errors++; $display("FAIL bsm_pc got=%h exp=00000100", pc_IF); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL bsm_misalign got=%b exp=1", misalign); end
    checks++; if (cnt_stall !== 32'd0) begin errors++; $display("FAIL bsm_cnt_stall got=%0d exp=0", cnt_stall); end
    checks++; if ({valid_ID, valid_EX} !== 2'b00) begin errors++; $display("FAIL bsm_valid got=%b exp=00", {valid_ID, valid_EX}); end
    EX_br_sel = 1'b1; br_target = 32'h80;
    step();
    idle_inputs();
    repeat (3) step();
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL bsm_sticky got=%b exp=1", misalign); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL bsm_clear got=%b exp=0", misalign); end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_rst got=%h exp=fffffffc", pc2); end
    step();
    checks++; if (pc2 !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=00000000", pc2); end
    repeat (16) step();
    checks++; if (c2_cycle !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d exp=1", c2_cycle); end
    checks++; if (cnt_cycle !== 32'd17) begin errors++; $display("FAIL wrap_cnt32 got=%0d exp=17", cnt_cycle); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_freeze();
    test_branch_stall_misalign();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
